// File: rtl/rotator_pkg.sv
// Shared definitions for the rotator family: amount-width helper and direction tag.
package rotator_pkg;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_e;

    // Number of rotate-amount bits (and pipeline stages) for an n-bit word.
    function automatic int unsigned amt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_left_rotator_pipe_if.sv
// Valid/ready word stream into and out of the left rotator pipeline.
interface param_left_rotator_pipe_if
    import rotator_pkg::*;
#(
    parameter int unsigned N = 10
);
    localparam int unsigned S = amt_width(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [S-1:0] in_amt;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/param_left_rotator_pipe_rotl_stage.sv
// One pipeline stage: registered conditional left rotate by 2^K with valid/ready.
module rotl_stage
    import rotator_pkg::*;
#(
    parameter int unsigned  N = 10,
    parameter int unsigned  K = 0,
    localparam int unsigned S = amt_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [N-1:0] up_data,
    input  logic [S-1:0] up_amt,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [N-1:0] dn_data,
    output logic [S-1:0] dn_amt
);

    // Effective rotation of this stage; reduced mod N so any K is well formed.
    localparam int unsigned R = (32'd1 << K) % N;

    logic         v_q;
    logic [N-1:0] d_q;
    logic [S-1:0] a_q;
    logic [N-1:0] rot;
    logic         advance;

    // Fixed wiring: input bit i lands on bit (i+R) mod N.
    for (genvar i = 0; i < N; i++) begin : g_rot
        assign rot[(i + R) % N] = up_data[i];
    end

    // Stage may load when empty or when its content leaves this cycle.
    assign advance  = !v_q || dn_ready;
    assign up_ready = advance;

    // Valid bit: cleared by reset, otherwise follows upstream on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (advance) begin
            v_q <= up_valid;
        end
    end

    // Payload: rotate when this stage's amount bit is set, carry the amount on.
    always_ff @(posedge clk) begin
        if (advance && up_valid) begin
            d_q <= up_amt[K] ? rot : up_data;
            a_q <= up_amt;
        end
    end

    assign dn_valid = v_q;
    assign dn_data  = d_q;
    assign dn_amt   = a_q;

endmodule

// File: rtl/param_left_rotator_pipe.sv
// S-stage pipelined left rotator; stage k conditionally rotates by 2^k.
// The bus interface instance must be parameterised with the same N.
module param_left_rotator_pipe
    import rotator_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    param_left_rotator_pipe_if.slave  bus
);

    localparam int unsigned S = amt_width(N);

    logic         vld [S+1];
    logic         rdy [S+1];
    logic [N-1:0] dat [S+1];
    logic [S-1:0] amt [S+1];
    logic [S-1:0] tail_amt_unused;

    assign vld[0]       = bus.in_valid;
    assign dat[0]       = bus.in_data;
    assign amt[0]       = bus.in_amt;
    assign bus.in_ready = rdy[0];
    assign rdy[S]       = bus.out_ready;

    for (genvar k = 0; k < S; k++) begin : g_stage
        rotl_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (dat[k]),
            .up_amt   (amt[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (dat[k+1]),
            .dn_amt   (amt[k+1])
        );
    end

    // The amount has no further use after the last stage.
    assign tail_amt_unused = amt[S];

    // Data registers are not reset, so the output is forced to zero when idle.
    assign bus.out_valid = vld[S];
    assign bus.out_data  = vld[S] ? dat[S] : '0;

endmodule
